sram_rw_initiator: RTL and testbench
====================================

SRAM_RW_INITIATOR -- requirements
Module: sram_rw_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, SRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 128, SRAM word width in bits.
REQ-003 SHALL have parameter MASK_W, default 4, write-mask segments; DATA_W divisible by MASK_W.
REQ-004 SHALL have parameter RSP_DEPTH, default 3, read-response FIFO entries; minimum 2.
REQ-005 SHALL have these ports:
  clk  in  1  sole clock, rising edge.
  rstn  in  1  asynchronous, active-low reset.
  req_valid  in  1  request offered.
  req_ready  out  1  request accepted when high with req_valid.
  req_write  in  1  1=write, 0=read.
  req_addr  in  ADDR_W  word address.
  req_wdata  in  DATA_W  write data.
  req_wmask  in  MASK_W  per-segment write enable.
  rsp_valid  out  1  read data available.
  rsp_ready  in  1  consumer takes read data.
  rsp_rdata  out  DATA_W  read data, in request order.
  init_done  out  1  block is accepting requests.
  RW0_en / RW0_wmode / RW0_addr / RW0_wmask / RW0_wdata  out  1/1/ADDR_W/MASK_W/DATA_W  drive the single-port SRAM RW0 port.
  RW0_rdata  in  DATA_W  SRAM read data, valid only the cycle after a read enable.

Function
REQ-006 Handshake: a request is accepted in the cycle req_valid && req_ready; in that same cycle RW0_en=1 and RW0_wmode/addr/wmask/wdata equal req_write/addr/wmask/wdata (combinational).
REQ-007 req_ready SHALL be 1 only in state RUN and when (fifo_count + rd_inflight) < RSP_DEPTH; it SHALL NOT depend on req_write, req_valid or rsp_ready.
REQ-008 RW0_en SHALL be 0 in any cycle with no accepted request and no init write.
REQ-009 rd_inflight SHALL be a 1-bit register set on the cycle after an accepted read and cleared otherwise.
REQ-010 When rd_inflight=1, RW0_rdata SHALL be pushed into the response FIFO that cycle; read-to-rsp_valid latency is 2 cycles from acceptance when the FIFO is empty.
REQ-011 Writes SHALL produce no response.
REQ-012 rsp_valid = FIFO not empty; rsp_rdata = FIFO head; pop on rsp_valid && rsp_ready; simultaneous push and pop SHALL keep count unchanged.
REQ-013 REQ-007 guarantees no push into a full FIFO; a push to a full FIFO is an assertion failure.
REQ-014 With rsp_ready held at 1 and RSP_DEPTH>=3, back-to-back reads SHALL sustain one acceptance per cycle.
REQ-015 Reads and writes SHALL complete in acceptance order; a read following a write to the same address SHALL return the written data.
REQ-016 State machine: INIT -> RUN when init sweep completes; RUN is terminal until reset.

Reset
REQ-017 On rstn low, asynchronously: FIFO empty, rd_inflight=0, rsp_valid=0, req_ready=0, RW0_en=0, state=INIT, init address=0, init_done=0.
REQ-018 Reset mid-operation SHALL discard in-flight and buffered read data; no response SHALL be emitted for them.

Configuration
REQ-019 Macro SRAM_INIT_SWEEP_EN defined: state INIT writes address 0..2^ADDR_W-1 sequentially, one per cycle, RW0_wmode=1, RW0_wmask all ones, RW0_wdata=0; takes exactly 2^ADDR_W cycles; enters RUN and sets init_done=1 the cycle after writing the last address.
REQ-020 Macro undefined: INIT lasts one cycle after reset release with RW0_en=0, then RUN and init_done=1.

Structure
REQ-021 Package sram_initiator_pkg SHALL hold the state enum (INIT, RUN) and default parameter constants.
REQ-022 Response FIFO SHALL be sub-module sram_rsp_fifo (parameterised DATA_W, RSP_DEPTH, own count, full/empty).

Verification
REQ-023 Macro on, ADDR_W=9: release reset -> 512 consecutive cycles RW0_en=1, wmode=1, addr 0..511, wdata=0; init_done=1 after address 511.
REQ-024 Write addr 0x05 data 0xA5..A5 mask 4'hF, then read 0x05 -> rsp_rdata=0xA5..A5 two cycles after read acceptance.
REQ-025 Write mask 4'b0010 data all ones to a zeroed word, read back -> bits 63:32 set, others 0.
REQ-026 rsp_ready=0, issue 4 reads -> exactly 3 accepted, req_ready=0 thereafter; raise rsp_ready -> 3 responses in order, 4th accepted.
REQ-027 rsp_ready=1, 10 back-to-back reads -> 10 acceptances in 10 cycles, responses in order.
REQ-028 Assert rstn low with 2 buffered and 1 in-flight read -> rsp_valid=0 immediately, no stale responses after re-init.

Source files
------------

// File: rtl/sram_initiator_pkg.sv
// Shared types and default parameters for the SRAM read/write initiator.
package sram_initiator_pkg;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

  localparam int unsigned DefAddrW    = 9;
  localparam int unsigned DefDataW    = 128;
  localparam int unsigned DefMaskW    = 4;
  localparam int unsigned DefRspDepth = 3;

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_rw_initiator_if.sv
// Request/response channel plus single-port SRAM RW0 bundle for sram_rw_initiator.
// The slave modport is the initiator's view; master is the requester/SRAM side.
interface sram_rw_initiator_if
  import sram_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned MASK_W = DefMaskW
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  logic              RW0_en;
  logic              RW0_wmode;
  logic [ADDR_W-1:0] RW0_addr;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready, RW0_rdata,
    output req_ready, rsp_valid, rsp_rdata, RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready, RW0_rdata,
    input  req_ready, rsp_valid, rsp_rdata, RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata
  );

endinterface

// File: rtl/sram_rsp_fifo.sv
// Read-response FIFO: ring buffer of RSP_DEPTH words with occupancy count.
module sram_rsp_fifo
  import sram_initiator_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned RSP_DEPTH = DefRspDepth,
  localparam int unsigned CntW     = cnt_width(RSP_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CntW-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(RSP_DEPTH);

  logic [DATA_W-1:0] mem_q [RSP_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(RSP_DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign pop     = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CntW'(push_i) - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o));

endmodule

// File: rtl/sram_rw_initiator.sv
// Request/response front end for a single-port SRAM with in-order read responses.
// Define SRAM_INIT_SWEEP_EN to zero the whole SRAM after reset before accepting requests.
module sram_rw_initiator
  import sram_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned MASK_W    = DefMaskW,
  parameter int unsigned RSP_DEPTH = DefRspDepth
) (
  input  logic               clk,
  input  logic               rstn,
  sram_rw_initiator_if.slave bus,
  output logic               init_done
);

  localparam int unsigned CntW = cnt_width(RSP_DEPTH);
  localparam int unsigned OutW = CntW + 1;

  if ((DATA_W % MASK_W) != 0 || RSP_DEPTH < 2 || ADDR_W == 0) begin : g_param_err
    $error("sram_rw_initiator: invalid parameter combination");
  end

  state_e          state_q, state_d;
  logic            rd_inflight_q, rd_inflight_d;
  logic            accept, room;
  logic            fifo_empty, fifo_full;
  logic [CntW-1:0] fifo_count;
  logic [OutW-1:0] outstanding;
`ifdef SRAM_INIT_SWEEP_EN
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
`endif

  // A read in flight already owns a FIFO slot, so it counts against the room check.
  assign outstanding   = OutW'(fifo_count) + OutW'(rd_inflight_q);
  assign room          = outstanding < OutW'(RSP_DEPTH);
  assign bus.req_ready = (state_q == StRun) && room;
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_inflight_d = accept && !bus.req_write;
  assign init_done     = (state_q == StRun);
  assign bus.rsp_valid = !fifo_empty;

  always_comb begin
    state_d       = state_q;
    bus.RW0_en    = accept;
    bus.RW0_wmode = bus.req_write;
    bus.RW0_addr  = bus.req_addr;
    bus.RW0_wmask = bus.req_wmask;
    bus.RW0_wdata = bus.req_wdata;
`ifdef SRAM_INIT_SWEEP_EN
    init_addr_d   = init_addr_q;
`endif
    unique case (state_q)
      StInit: begin
`ifdef SRAM_INIT_SWEEP_EN
        bus.RW0_en    = 1'b1;
        bus.RW0_wmode = 1'b1;
        bus.RW0_addr  = init_addr_q;
        bus.RW0_wmask = '1;
        bus.RW0_wdata = '0;
        init_addr_d   = init_addr_q + 1'b1;
        if (init_addr_q == '1) begin
          state_d = StRun;
        end
`else
        state_d = StRun;
`endif
      end
      StRun: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StInit;
      rd_inflight_q <= 1'b0;
`ifdef SRAM_INIT_SWEEP_EN
      init_addr_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rd_inflight_q <= rd_inflight_d;
`ifdef SRAM_INIT_SWEEP_EN
      init_addr_q   <= init_addr_d;
`endif
    end
  end

  sram_rsp_fifo #(
    .DATA_W   (DATA_W),
    .RSP_DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i      (clk),
    .rst_ni     (rstn),
    .push_i     (rd_inflight_q),
    .push_data_i(bus.RW0_rdata),
    .pop_i      (bus.rsp_ready),
    .head_o     (bus.rsp_rdata),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  a_no_ready_when_full: assert property (@(posedge clk) disable iff (!rstn)
    !(fifo_full && bus.req_ready));

endmodule

// File: tb/tb_sram_rw_initiator.sv
// Bench for sram_rw_initiator: behavioural SRAM, queue-based reference model, directed + random.
module tb_sram_rw_initiator;
  import sram_initiator_pkg::*;

  localparam int unsigned AW     = 9;
  localparam int unsigned DW     = 128;
  localparam int unsigned MW     = 4;
  localparam int unsigned DEPTH  = 3;
  localparam int unsigned SEGW   = DW / MW;
  localparam int unsigned NWORDS = 1 << AW;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic init_done;
  int   n_chk  = 0;
  int   n_fail = 0;

  sram_rw_initiator_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();

  sram_rw_initiator #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MASK_W   (MW),
    .RSP_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int s = 0; s < MW; s++) begin
      if (m[s]) r[s*SEGW +: SEGW] = nw[s*SEGW +: SEGW];
    end
    return r;
  endfunction

  // Behavioural SRAM: read data appears the cycle after the enable.
  logic [DW-1:0] sram [NWORDS];
  always @(posedge clk) begin
    if (bus.RW0_en) begin
      if (bus.RW0_wmode) begin
        for (int s = 0; s < MW; s++) begin
          if (bus.RW0_wmask[s]) sram[bus.RW0_addr][s*SEGW +: SEGW] <= bus.RW0_wdata[s*SEGW +: SEGW];
        end
      end else begin
        bus.RW0_rdata <= sram[bus.RW0_addr];
      end
    end
  end

  // Reference model: memory image plus queue of accepted, not yet consumed reads.
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [NWORDS];
  bit            model_run = 1'b0;
  int            cyc = 0;
  int            acc_log[$];

  always @(negedge clk) begin
    bit exp_rdy;
    bit exp_vld;
    cyc++;
    if (!rstn) begin
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rw0_en", bus.RW0_en, 0);
      chk("rst_init_done", init_done, 0);
      exp_q.delete();
    end else if (model_run) begin
      exp_rdy = exp_q.size() < DEPTH;
      exp_vld = exp_q.size() > 0 && (cyc - exp_q[0].cyc >= 2);
      chk("init_done", init_done, 1);
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("rsp_valid", bus.rsp_valid, exp_vld);
      chk("rw0_en", bus.RW0_en, bus.req_valid && exp_rdy);
      if (exp_vld) chk("rsp_rdata", bus.rsp_rdata, exp_q[0].data);
      if (bus.RW0_en) begin
        chk("rw0_wmode", bus.RW0_wmode, bus.req_write);
        chk("rw0_addr", bus.RW0_addr, bus.req_addr);
        if (bus.req_write) begin
          chk("rw0_wdata", bus.RW0_wdata, bus.req_wdata);
          chk("rw0_wmask", bus.RW0_wmask, bus.req_wmask);
        end
      end
      if (bus.req_valid && bus.req_ready) acc_log.push_back(cyc);
      if (exp_vld && bus.rsp_ready) void'(exp_q.pop_front());
      if (bus.req_valid && exp_rdy) begin
        if (bus.req_write) begin
          ref_mem[bus.req_addr] = merge(ref_mem[bus.req_addr], bus.req_wdata, bus.req_wmask);
        end else begin
          exp_q.push_back('{ref_mem[bus.req_addr], cyc});
        end
      end
    end
  end

  bit rand_rdy = 1'b0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Leaves the caller one time unit after a rising edge.
  task automatic do_reset();
    model_run     = 1'b0;
    rstn          = 1'b0;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
`ifdef SRAM_INIT_SWEEP_EN
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;
    for (int i = 0; i < NWORDS; i++) begin
      @(negedge clk);
      chk("sweep_en", bus.RW0_en, 1);
      chk("sweep_wmode", bus.RW0_wmode, 1);
      chk("sweep_addr", bus.RW0_addr, DW'(i));
      chk("sweep_wdata", bus.RW0_wdata, 0);
      chk("sweep_wmask", bus.RW0_wmask, 4'hF);
      chk("sweep_init_done", init_done, 0);
    end
`else
    @(negedge clk);
    chk("init_rw0_en", bus.RW0_en, 0);
    chk("init_done_low", init_done, 0);
    chk("init_req_ready", bus.req_ready, 0);
`endif
    @(negedge clk);
    chk("init_done_high", init_done, 1);
    @(posedge clk);
    #1;
    model_run = 1'b1;
  endtask

  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [MW-1:0] m);
    int t;
    t = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wmask = m;
    @(negedge clk);
    while (!bus.req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) chk("accept_timeout", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.rsp_ready = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_chk);
    $fatal(1);
  end

  initial begin
    int          t;
    int          cnt;
    int          span;
    int unsigned g;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NWORDS; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    #1;
    do_reset();

    // Write then read back the same word: data two cycles after acceptance.
    issue(1'b1, 9'h05, {16{8'hA5}}, 4'hF);
    issue(1'b0, 9'h05, '0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("raw_valid", bus.rsp_valid, 1);
    chk("raw_data", bus.rsp_rdata, {16{8'hA5}});
    @(posedge clk);
    #1;

    // Segment 1 only written into a zero word.
    issue(1'b1, 9'h10, '1, 4'b0010);
    issue(1'b0, 9'h10, '0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("mask_valid", bus.rsp_valid, 1);
    chk("mask_data", bus.rsp_rdata, {64'h0, 32'hFFFF_FFFF, 32'h0});
    @(posedge clk);
    #1;

    // Backpressure: only three reads fit while the consumer stalls.
    for (int i = 1; i <= 4; i++) issue(1'b1, AW'(i), {4{32'h1111_0000 + 32'(i)}}, 4'hF);
    bus.rsp_ready = 1'b0;
    acc_log.delete();
    for (int i = 1; i <= 3; i++) issue(1'b0, AW'(i), '0, '0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 9'h004;
    repeat (4) begin
      @(negedge clk);
      chk("stall_req_ready", bus.req_ready, 0);
    end
    chk("stall_accepts", acc_log.size(), 3);
    chk("stall_head", bus.rsp_rdata, {4{32'h1111_0001}});
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("fourth_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    drain();
    chk("fourth_accepts", acc_log.size(), 4);

    // Back-to-back reads at full rate.
    acc_log.delete();
    for (int i = 0; i < 10; i++) issue(1'b0, AW'(i), '0, '0);
    span = (acc_log.size() >= 10) ? acc_log[9] - acc_log[0] : -1;
    chk("b2b_count", acc_log.size(), 10);
    chk("b2b_span", span, 9);
    drain();

    // Randomized traffic over a small address window.
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
            {$urandom, $urandom, $urandom, $urandom}, MW'($urandom_range(0, 15)));
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    drain();

    // Reset with two buffered and one in-flight read.
    bus.rsp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) issue(1'b0, AW'(i), '0, '0);
    chk("pre_rst_valid", bus.rsp_valid, 1);
    rstn = 1'b0;
    #1;
    chk("rst_async_valid", bus.rsp_valid, 0);
    chk("rst_async_ready", bus.req_ready, 0);
    do_reset();
    bus.rsp_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid) cnt++;
    end
    chk("stale_rsp", cnt, 0);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
